// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader and the ALU verification bench:
// loader FSM state encoding, op-code constants and the legal-op check.
package alu_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_GO   = 3'd3,
        S_WAIT = 3'd4,
        S_SHOW = 3'd5
    } loader_state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EZ  = 3'b111;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_LT, OP_EZ: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_operand_loader_key_debounce.sv
// Debouncer for one active-low key: 2-flop synchronizer, stability counter,
// and a single-cycle press pulse on the accepted 1->0 transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Any sample matching the accepted level restarts the count, so a
    // bouncing key never accumulates towards a new level.
    always_comb begin
        sync_d  = {sync_q[0], key_n_i};
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequences operand A, operand B and the op code from one switch bank into the
// ALU, issues the operation and latches the ALU's registered result for display.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             key_enter_n,
    input  logic             key_clear_n,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       control,
    output logic             op_go,
    output logic [WIDTH-1:0] result_latched,
    output logic             result_valid,
    output logic             op_err,
    output logic [2:0]       stage
);

    logic enter_press;
    logic clear_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock   (clock),
        .reset   (reset),
        .key_n_i (key_enter_n),
        .press_o (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock   (clock),
        .reset   (reset),
        .key_n_i (key_clear_n),
        .press_o (clear_press)
    );

    loader_state_t    state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       ctl_q;
    logic             go_q, valid_q, err_q;

    // op_go is registered on the entry into S_GO so it is high for exactly
    // the S_GO cycle; clear overrides every state including S_GO/S_WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            res_q   <= '0;
            go_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (clear_press) begin
                state_q <= S_A;
                a_q     <= '0;
                b_q     <= '0;
                ctl_q   <= '0;
                res_q   <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (enter_press) begin
                            a_q     <= sw;
                            state_q <= S_B;
                        end
                    end
                    S_B: begin
                        if (enter_press) begin
                            b_q     <= sw;
                            state_q <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (enter_press) begin
                            if (is_legal_op(sw[2:0])) begin
                                ctl_q   <= sw[2:0];
                                err_q   <= 1'b0;
                                go_q    <= 1'b1;
                                state_q <= S_GO;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_GO: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        res_q   <= alu_result;
                        valid_q <= 1'b1;
                        state_q <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (enter_press) begin
                            valid_q <= 1'b0;
                            state_q <= S_A;
                        end
                    end
                    default: begin
                        state_q <= S_A;
                    end
                endcase
            end
        end
    end

    assign A              = a_q;
    assign B              = b_q;
    assign control        = ctl_q;
    assign op_go          = go_q;
    assign result_latched = res_q;
    assign result_valid   = valid_q;
    assign op_err         = err_q;
    assign stage          = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with an ideal registered ALU model;
// expected results are queued at stimulus time and checked by a monitor.
module tb_alu_operand_loader;

    localparam int unsigned W = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw = '0;
    logic         key_enter_n = 1'b1;
    logic         key_clear_n = 1'b1;
    logic [W-1:0] alu_result = '0;
    logic [W-1:0] A, B, result_latched;
    logic [2:0]   control, stage;
    logic         op_go, result_valid, op_err;

    alu_operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .sw             (sw),
        .key_enter_n    (key_enter_n),
        .key_clear_n    (key_clear_n),
        .alu_result     (alu_result),
        .A              (A),
        .B              (B),
        .control        (control),
        .op_go          (op_go),
        .result_latched (result_latched),
        .result_valid   (result_valid),
        .op_err         (op_err),
        .stage          (stage)
    );

    always #5 clock = ~clock;

    // Ideal ALU: one register stage between operands and RESULT.
    always @(posedge clock) begin
        case (control)
            3'b000:  alu_result <= A + B;
            3'b001:  alu_result <= A - B;
            3'b100:  alu_result <= {5'b0, A == B};
            3'b101:  alu_result <= {5'b0, $signed(A) > $signed(B)};
            3'b110:  alu_result <= {5'b0, $signed(A) < $signed(B)};
            default: alu_result <= {5'b0, A == '0};
        endcase
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   c;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   go_cnt   = 0;
    int   cyc      = 0;
    int   go_cyc   = 0;
    logic rv_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts op_go pulses and checks every new result against the queue.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            rv_prev = 1'b0;
        end else begin
            if (op_go) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if (result_valid && !rv_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_A", 32'(A), 32'(e.a));
                    check("sb_B", 32'(B), 32'(e.b));
                    check("sb_control", 32'(control), 32'(e.c));
                    check("sb_result", 32'(result_latched), 32'(e.r));
                    check("sb_go_to_result_cycles", 32'(cyc - go_cyc), 32'd2);
                    check("sb_stage_show", 32'(stage), 32'd5);
                end
            end
            rv_prev = result_valid;
        end
    end

    task automatic press(input logic [W-1:0] v);
        @(negedge clock);
        sw = v;
        key_enter_n = 1'b0;
        repeat (12) @(negedge clock);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_A"}, 32'(A), 32'd0);
        check({tag, "_B"}, 32'(B), 32'd0);
        check({tag, "_control"}, 32'(control), 32'd0);
        check({tag, "_op_go"}, 32'(op_go), 32'd0);
        check({tag, "_result"}, 32'(result_latched), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_op_err"}, 32'(op_err), 32'd0);
        check({tag, "_stage"}, 32'(stage), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   k;
        int   changes;
        logic seen;

        // Reset values
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic add: 5 + 3
        press(6'b000101);
        check("t1_stage_after_A", 32'(stage), 32'd1);
        check("t1_A", 32'(A), 32'd5);
        press(6'b000011);
        check("t1_stage_after_B", 32'(stage), 32'd2);
        check("t1_B", 32'(B), 32'd3);
        e = '{a: 6'd5, b: 6'd3, c: 3'b000, r: 6'b001000};
        sb.push_back(e);
        press(6'b000000);
        check("t1_go_count", 32'(go_cnt), 32'd1);
        check("t1_stage", 32'(stage), 32'd5);
        check("t1_valid", 32'(result_valid), 32'd1);
        check("t1_result", 32'(result_latched), 32'd8);

        // Bounce: 0,1,0,1 in 2-cycle segments, then stable low
        @(negedge clock);
        sw = 6'b111111;
        for (int s = 0; s < 4; s++) begin
            key_enter_n = s[0];
            repeat (2) @(negedge clock);
        end
        check("t2_no_event_during_bounce", 32'(stage), 32'd5);
        key_enter_n = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (!seen && stage != 3'd5) begin
                seen = 1'b1;
                k = i;
            end
        end
        check("t2_event_seen", 32'(seen), 32'd1);
        check("t2_latency_ge6", 32'(k >= 6), 32'd1);
        check("t2_stage_advanced_once", 32'(stage), 32'd0);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clock);
        check("t2_stage_after_release", 32'(stage), 32'd0);
        check("t2_valid_cleared", 32'(result_valid), 32'd0);
        check("t2_A_kept", 32'(A), 32'd5);

        // Illegal op then legal SUB: 10 - 4
        press(6'b001010);
        press(6'b000100);
        press(6'b000011);
        check("t3_op_err", 32'(op_err), 32'd1);
        check("t3_stage_stays", 32'(stage), 32'd2);
        check("t3_control_unchanged", 32'(control), 32'd0);
        check("t3_no_go", 32'(go_cnt), 32'd1);
        e = '{a: 6'd10, b: 6'd4, c: 3'b001, r: 6'd6};
        sb.push_back(e);
        press(6'b000001);
        check("t3_op_err_cleared", 32'(op_err), 32'd0);
        check("t3_control", 32'(control), 32'd1);
        check("t3_go_count", 32'(go_cnt), 32'd2);
        check("t3_stage", 32'(stage), 32'd5);

        // Clear and enter together in S_SHOW
        @(negedge clock);
        key_enter_n = 1'b0;
        key_clear_n = 1'b0;
        repeat (12) @(negedge clock);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (12) @(negedge clock);
        check("t4_stage", 32'(stage), 32'd0);
        check("t4_A", 32'(A), 32'd0);
        check("t4_B", 32'(B), 32'd0);
        check("t4_control", 32'(control), 32'd0);
        check("t4_valid", 32'(result_valid), 32'd0);
        check("t4_result", 32'(result_latched), 32'd0);
        check("t4_no_extra_go", 32'(go_cnt), 32'd2);

        // Enter event injected during S_GO is dropped: 20 + 7
        press(6'd20);
        press(6'd7);
        e = '{a: 6'd20, b: 6'd7, c: 3'b000, r: 6'b011011};
        sb.push_back(e);
        @(negedge clock);
        sw = 6'b000000;
        key_enter_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (stage == 3'd3) seen = 1'b1;
        end
        check("t5_reached_S_GO", 32'(seen), 32'd1);
        force dut.enter_press = 1'b1;
        @(negedge clock);
        release dut.enter_press;
        key_enter_n = 1'b1;
        changes = 0;
        repeat (14) begin
            @(negedge clock);
            if (stage != 3'd5) changes++;
        end
        check("t5_stage_show", 32'(stage), 32'd5);
        check("t5_result", 32'(result_latched), 32'd27);
        check("t5_go_count", 32'(go_cnt), 32'd3);

        // Reset during S_WAIT
        press(6'b000000);
        check("t6_back_to_A", 32'(stage), 32'd0);
        press(6'd1);
        press(6'd1);
        @(negedge clock);
        sw = 6'b000000;
        key_enter_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (stage == 3'd4) seen = 1'b1;
        end
        check("t6_reached_S_WAIT", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("t6_async");
        key_enter_n = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_vals("t6_held");
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check("t6_stage_idle", 32'(stage), 32'd0);
        check("t6_go_count", 32'(go_cnt), 32'd4);
        check("t6_no_result", 32'(result_valid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
